sva_result_collector: RTL and testbench

SVA_RESULT_COLLECTOR -- requirements
Module: sva_result_collector

---
 rtl/sva_result_collector.sv | 171 +++++++++++++++++
 tb/tb_sva_result_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sva_result_collector.sv
// Collects assertion checker verdicts into counters and a timestamped
// event FIFO, with first-fail capture and optional halt on fail.
module sva_result_collector #(
  parameter int CNT_WIDTH    = 16,
  parameter int TS_WIDTH     = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 clr,
  input  logic                 enable,
  input  logic                 gclk_posedge_flag,
  input  logic                 succ,
  input  logic                 fail,
  input  logic                 lazy_succ,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [1:0]           evt_type,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic [CNT_WIDTH-1:0] succ_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0] lazy_cnt,
  output logic                 first_fail_vld,
  output logic [TS_WIDTH-1:0]  first_fail_ts,
  output logic                 ovf,
  output logic [1:0]           state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] succ_q, succ_d;
  logic [CNT_WIDTH-1:0] fail_q, fail_d;
  logic [CNT_WIDTH-1:0] lazy_q, lazy_d;
  logic                 ffv_q, ffv_d;
  logic [TS_WIDTH-1:0]  ffts_q, ffts_d;
  logic                 ovf_q, ovf_d;
  logic [AW:0]          wr_q, wr_d;
  logic [AW:0]          rd_q, rd_d;
  logic [TS_WIDTH+1:0]  mem_q [FIFO_DEPTH];
  logic [TS_WIDTH+1:0]  head;

  logic       acc;
  logic       pop;
  logic       full;
  logic       push_req;
  logic       push_ok;
  logic       mem_we;
  logic [1:0] push_type;

  // Pointers carry an extra wrap bit to tell full from empty.
  assign evt_valid = (wr_q != rd_q);
  assign head      = mem_q[rd_q[AW-1:0]];
  assign evt_type  = evt_valid ? head[TS_WIDTH+1:TS_WIDTH] : 2'b00;
  assign evt_ts    = evt_valid ? head[TS_WIDTH-1:0] : '0;

  always_comb begin
    acc      = (state_q == RUN);
    pop      = evt_valid & evt_ready;
    full     = (wr_q[AW] != rd_q[AW]) &&
               (wr_q[AW-1:0] == rd_q[AW-1:0]);
    push_req = acc & (succ | fail | lazy_succ);
    push_ok  = push_req & (~full | pop);
    mem_we   = push_ok & ~clr;

    push_type = 2'b00;
    priority case (1'b1)
      fail:      push_type = 2'b10;
      succ:      push_type = 2'b01;
      lazy_succ: push_type = 2'b11;
      default:   push_type = 2'b00;
    endcase

    state_d = state_q;
    ts_d    = ts_q;
    succ_d  = succ_q;
    fail_d  = fail_q;
    lazy_d  = lazy_q;
    ffv_d   = ffv_q;
    ffts_d  = ffts_q;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;

    if (acc) begin
      if (succ && succ_q != '1)      succ_d = succ_q + 1'b1;
      if (fail && fail_q != '1)      fail_d = fail_q + 1'b1;
      if (lazy_succ && lazy_q != '1) lazy_d = lazy_q + 1'b1;
      if (fail && !ffv_q) begin
        ffv_d  = 1'b1;
        ffts_d = ts_q;
      end
      if (gclk_posedge_flag) ts_d = ts_q + 1'b1;
    end

    if (push_ok)             wr_d  = wr_q + 1'b1;
    if (pop)                 rd_d  = rd_q + 1'b1;
    if (push_req & ~push_ok) ovf_d = 1'b1;

    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (STOP_ON_FAIL && fail) state_d = HALT;
        else if (!enable)         state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d = IDLE;
      ts_d    = '0;
      succ_d  = '0;
      fail_d  = '0;
      lazy_d  = '0;
      ffv_d   = 1'b0;
      ffts_d  = '0;
      ovf_d   = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ts_q    <= '0;
      succ_q  <= '0;
      fail_q  <= '0;
      lazy_q  <= '0;
      ffv_q   <= 1'b0;
      ffts_q  <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
      lazy_q  <= lazy_d;
      ffv_q   <= ffv_d;
      ffts_q  <= ffts_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[wr_q[AW-1:0]] <= {push_type, ts_q};
  end

  assign state          = state_q;
  assign succ_cnt       = succ_q;
  assign fail_cnt       = fail_q;
  assign lazy_cnt       = lazy_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_ts  = ffts_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_sva_result_collector.sv
// Bench for sva_result_collector: two configurations driven in lockstep
// and checked every cycle against a queue-level verdict model.
module tb_sva_result_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, enable = 1'b0, gclk = 1'b0;
  logic succ = 1'b0, fail = 1'b0, lazy = 1'b0, evt_ready = 1'b0;

  logic       v0, ffv0, ovf0;
  logic [1:0] ty0, st0;
  logic [3:0] ts0, sc0, fc0, lc0, fft0;

  logic        v1, ffv1, ovf1;
  logic [1:0]  ty1, st1;
  logic [15:0] ts1, sc1, fc1, lc1, fft1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sva_result_collector #(
    .CNT_WIDTH(4), .TS_WIDTH(4), .FIFO_DEPTH(8), .STOP_ON_FAIL(1'b0)
  ) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr), .enable(enable),
    .gclk_posedge_flag(gclk), .succ(succ), .fail(fail),
    .lazy_succ(lazy), .evt_valid(v0), .evt_ready(evt_ready),
    .evt_type(ty0), .evt_ts(ts0), .succ_cnt(sc0), .fail_cnt(fc0),
    .lazy_cnt(lc0), .first_fail_vld(ffv0), .first_fail_ts(fft0),
    .ovf(ovf0), .state(st0)
  );

  sva_result_collector #(
    .CNT_WIDTH(16), .TS_WIDTH(16), .FIFO_DEPTH(4), .STOP_ON_FAIL(1'b1)
  ) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr), .enable(enable),
    .gclk_posedge_flag(gclk), .succ(succ), .fail(fail),
    .lazy_succ(lazy), .evt_valid(v1), .evt_ready(evt_ready),
    .evt_type(ty1), .evt_ts(ts1), .succ_cnt(sc1), .fail_cnt(fc1),
    .lazy_cnt(lc1), .first_fail_vld(ffv1), .first_fail_ts(fft1),
    .ovf(ovf1), .state(st1)
  );

  localparam int TSMOD[2] = '{16, 65536};
  localparam int CMAX[2]  = '{15, 65535};
  localparam int DEP[2]   = '{8, 4};
  localparam bit STOP[2]  = '{1'b0, 1'b1};

  // Model: state 0 idle, 1 run, 2 halt; queue entries are type*65536+ts.
  int m_st[2], m_ts[2], m_sc[2], m_fc[2], m_lc[2], m_fft[2];
  bit m_ffv[2], m_ovf[2];
  int m_q[2][16];
  int m_n[2];

  task automatic mreset(input int k);
    m_st[k] = 0; m_ts[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    m_lc[k] = 0; m_fft[k] = 0; m_ffv[k] = 0; m_ovf[k] = 0;
    m_n[k] = 0;
  endtask

  task automatic step(input int k);
    int ty;
    if (clr) begin
      mreset(k);
      return;
    end
    if (m_n[k] > 0 && evt_ready) begin
      for (int i = 0; i < 15; i++) m_q[k][i] = m_q[k][i+1];
      m_n[k]--;
    end
    if (m_st[k] == 1) begin
      if (succ && m_sc[k] < CMAX[k]) m_sc[k]++;
      if (fail && m_fc[k] < CMAX[k]) m_fc[k]++;
      if (lazy && m_lc[k] < CMAX[k]) m_lc[k]++;
      ty = fail ? 2 : succ ? 1 : lazy ? 3 : 0;
      if (ty != 0) begin
        if (m_n[k] < DEP[k]) begin
          m_q[k][m_n[k]] = ty * 65536 + m_ts[k];
          m_n[k]++;
        end else m_ovf[k] = 1;
      end
      if (fail && !m_ffv[k]) begin
        m_ffv[k] = 1;
        m_fft[k] = m_ts[k];
      end
      if (gclk) m_ts[k] = (m_ts[k] + 1) % TSMOD[k];
      if (fail && STOP[k]) m_st[k] = 2;
      else if (!enable) m_st[k] = 0;
    end else if (m_st[k] == 0 && enable) m_st[k] = 1;
  endtask

  always @(posedge clk) if (rst_n) begin
    step(0);
    step(1);
  end

  always @(negedge rst_n) begin
    mreset(0);
    mreset(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input int st, input int v,
                          input int ty, input int ts, input int sc,
                          input int fc, input int lc, input int ffv,
                          input int fft, input int ov);
    string p;
    p = $sformatf("u%0d.", k);
    chk({p, "state"}, st, m_st[k]);
    chk({p, "evt_valid"}, v, int'(m_n[k] > 0));
    chk({p, "evt_type"}, ty, m_n[k] > 0 ? m_q[k][0] / 65536 : 0);
    chk({p, "evt_ts"}, ts, m_n[k] > 0 ? m_q[k][0] % 65536 : 0);
    chk({p, "succ_cnt"}, sc, m_sc[k]);
    chk({p, "fail_cnt"}, fc, m_fc[k]);
    chk({p, "lazy_cnt"}, lc, m_lc[k]);
    chk({p, "first_fail_vld"}, ffv, int'(m_ffv[k]));
    chk({p, "first_fail_ts"}, fft, m_fft[k]);
    chk({p, "ovf"}, ov, int'(m_ovf[k]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, st0, v0, ty0, ts0, sc0, fc0, lc0, ffv0, fft0, ovf0);
    cmp_inst(1, st1, v1, ty1, ts1, sc1, fc1, lc1, ffv1, fft1, ovf1);
  end

  task automatic cyc(input bit g, input bit s, input bit f, input bit l,
                     input bit r, input bit c = 1'b0);
    gclk = g; succ = s; fail = f; lazy = l; evt_ready = r; clr = c;
    @(negedge clk);
  endtask

  task automatic do_clr();
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic run_on();
    enable = 1'b1;
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    chk("rst.state", st0, 0);
    chk("rst.evt_valid", v0, 0);
    chk("rst.evt_ts", ts1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Window timestamps on two events
    run_on();
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("a.head_type", ty0, 1);
    chk("a.head_ts", ts0, 0);
    chk("a.succ_cnt", sc0, 1);
    chk("a.fail_cnt", fc0, 1);
    chk("a.ff_ts", fft0, 3);
    chk("a.halt", st1, 2);
    cyc(0, 0, 0, 0, 1);
    chk("a.second_type", ty0, 2);
    chk("a.second_ts", ts0, 3);
    cyc(0, 0, 0, 0, 1);
    chk("a.empty", v0, 0);
    do_clr();

    // Coincident verdicts push one fail entry
    run_on();
    cyc(0, 1, 1, 1, 0);
    chk("b.type", ty0, 2);
    chk("b.lazy_cnt", lc0, 1);
    chk("b.succ_cnt", sc0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("b.single", v0, 0);
    do_clr();

    // Overflow then simultaneous pop and push on a full FIFO
    run_on();
    repeat (9) cyc(0, 1, 0, 0, 0);
    chk("c.ovf", ovf0, 1);
    chk("c.succ_cnt", sc0, 9);
    chk("c.ovf_u1", ovf1, 1);
    cyc(0, 1, 0, 0, 1);
    chk("c.succ_cnt2", sc0, 10);
    n = 0;
    repeat (12) begin
      if (v0) n++;
      cyc(0, 0, 0, 0, 1);
    end
    chk("c.drained", n, 8);
    do_clr();

    // Counter saturation
    run_on();
    repeat (20) cyc(0, 1, 0, 0, 1);
    chk("d.sat4", sc0, 15);
    chk("d.nosat16", sc1, 20);
    do_clr();

    // Timestamp wrap
    run_on();
    repeat (17) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("e.ts_wrap", ts0, 1);
    chk("e.ts_wide", ts1, 17);
    do_clr();

    // Halt on fail, drain in halt, first fail held
    run_on();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("f.halt", st1, 2);
    chk("f.succ_ignored", sc1, 0);
    chk("f.u0_succ", sc0, 1);
    cyc(1, 0, 1, 0, 0);
    chk("f.ff_held", fft0, 1);
    chk("f.fail2", fc0, 2);
    enable = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk("f.drained", v1, 0);
    chk("f.still_halt", st1, 2);
    chk("f.u0_idle", st0, 0);
    enable = 1'b1;
    do_clr();
    chk("f.clr_state", st1, 0);
    chk("f.clr_ffv", ffv1, 0);

    // clr beats pulses; async reset with entries queued
    run_on();
    cyc(1, 1, 1, 1, 0, 1);
    chk("g.clr_prio", sc0, 0);
    chk("g.clr_idle", st0, 0);
    run_on();
    repeat (3) cyc(0, 1, 0, 0, 0);
    chk("g.queued", v0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("g.rst_valid", v0, 0);
    chk("g.rst_valid1", v1, 0);
    chk("g.rst_cnt", sc0, 0);
    chk("g.rst_state", st0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("g.no_early", sc0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("g.first_acc", sc0, 1);
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
